// File: rtl/pipe_ctrl_if.sv
// Hazard/run-control bundle between the pipeline datapath and pipe_ctrl.
// The master side drives the pipeline-register fields and the run-control pulses.
// The slave side (pipe_ctrl) returns the stall/bubble controls and the run state.
// The counter fields exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_ctrl_if;
  logic [3:0] D_icode;
  logic [3:0] E_icode;
  logic [3:0] M_icode;
  logic [3:0] d_srcA;
  logic [3:0] d_srcB;
  logic [3:0] E_dstM;
  logic       e_Cnd;
  logic [2:0] m_stat;
  logic [2:0] W_stat;
  logic       start;
  logic       step;
  logic       pause;

  logic       F_stall;
  logic       D_stall;
  logic       E_stall;
  logic       M_stall;
  logic       W_stall;
  logic       D_bubble;
  logic       E_bubble;
  logic       M_bubble;
  logic [1:0] cpu_state;
  logic       halted;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] mispred_cnt;
`endif

  modport master (
    output D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_Cnd, m_stat, W_stat,
    output start, step, pause,
    input  F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble, M_bubble,
    input  cpu_state, halted
`ifdef PIPE_PERF_CNT_EN
    , input cyc_cnt, stall_cnt, mispred_cnt
`endif
  );

  modport slave (
    input  D_icode, E_icode, M_icode, d_srcA, d_srcB, E_dstM, e_Cnd, m_stat, W_stat,
    input  start, step, pause,
    output F_stall, D_stall, E_stall, M_stall, W_stall, D_bubble, E_bubble, M_bubble,
    output cpu_state, halted
`ifdef PIPE_PERF_CNT_EN
    , output cyc_cnt, stall_cnt, mispred_cnt
`endif
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard control and run-control FSM for a Y86-style 5-stage pipeline.
// Stall and bubble outputs are purely combinational from the state and the hazard inputs.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  localparam logic [3:0] IMrmovq = 4'h5;
  localparam logic [3:0] IJxx    = 4'h7;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPopq   = 4'hB;
  localparam logic [3:0] RNone   = 4'hF;
  localparam logic [2:0] SHlt    = 3'd2;
  localparam logic [2:0] SAdr    = 3'd3;
  localparam logic [2:0] SIns    = 3'd4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10,
    StHalt = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic load_use, ret_hz, mispred, exc_m, exc_w, active;

  // Hazard detection terms
  always_comb begin
    load_use = ((bus.E_icode == IMrmovq) || (bus.E_icode == IPopq)) &&
               (bus.E_dstM != RNone) &&
               ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    ret_hz   = (bus.D_icode == IRet) || (bus.E_icode == IRet) || (bus.M_icode == IRet);
    mispred  = (bus.E_icode == IJxx) && !bus.e_Cnd;
    exc_m    = (bus.m_stat == SHlt) || (bus.m_stat == SAdr) || (bus.m_stat == SIns);
    exc_w    = (bus.W_stat == SHlt) || (bus.W_stat == SAdr) || (bus.W_stat == SIns);
    active   = (state_q == StRun) || (state_q == StStep);
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; HALT is sticky until reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
        end else if (bus.step) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (exc_w) begin
          state_d = StHalt;
        end else if (bus.pause) begin
          state_d = StIdle;
        end
      end
      StStep: begin
        state_d = exc_w ? StHalt : StIdle;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StIdle;
    endcase
  end

  // Stall/bubble outputs: frozen pipeline unless running or stepping
  always_comb begin
    bus.F_stall  = 1'b1;
    bus.D_stall  = 1'b1;
    bus.E_stall  = 1'b1;
    bus.M_stall  = 1'b1;
    bus.W_stall  = 1'b1;
    bus.D_bubble = 1'b0;
    bus.E_bubble = 1'b0;
    bus.M_bubble = 1'b0;
    if (active) begin
      bus.F_stall  = load_use | ret_hz;
      bus.D_stall  = load_use;
      bus.E_stall  = 1'b0;
      bus.M_stall  = 1'b0;
      bus.W_stall  = exc_w;
      bus.D_bubble = mispred | (ret_hz & ~load_use);
      bus.E_bubble = mispred | load_use;
      bus.M_bubble = exc_m | exc_w;
    end
    bus.cpu_state = state_q;
    bus.halted    = (state_q == StHalt);
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_cnt_q, stall_cnt_q, mispred_cnt_q;

  // Performance counters, advancing only while the pipeline is live
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt_q     <= '0;
      stall_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else if (active) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (load_use | ret_hz) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (mispred) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  // Counter outputs
  always_comb begin
    bus.cyc_cnt     = cyc_cnt_q;
    bus.stall_cnt   = stall_cnt_q;
    bus.mispred_cnt = mispred_cnt_q;
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of hazard vectors in RUN plus run-control sequences.
// Counter checks are compiled only when PIPE_PERF_CNT_EN is defined.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if pif ();

  pipe_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pif.slave)
  );

  typedef struct {
    logic [3:0] d_ic, e_ic, m_ic, srca, srcb, dstm;
    logic       cnd;
    logic [2:0] mst, wst;
    logic [4:0] stl;  // {F,D,E,M,W}
    logic [2:0] bub;  // {D,E,M}
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [4:0] stalls();
    return {pif.F_stall, pif.D_stall, pif.E_stall, pif.M_stall, pif.W_stall};
  endfunction

  function automatic logic [2:0] bubbles();
    return {pif.D_bubble, pif.E_bubble, pif.M_bubble};
  endfunction

  task automatic nops();
    pif.D_icode = 4'h1; pif.E_icode = 4'h1; pif.M_icode = 4'h1;
    pif.d_srcA = 4'hF; pif.d_srcB = 4'hF; pif.E_dstM = 4'hF;
    pif.e_Cnd = 1'b1; pif.m_stat = 3'd1; pif.W_stat = 3'd1;
  endtask

  task automatic ctl(input logic s, input logic st, input logic p);
    pif.start = s; pif.step = st; pif.pause = p;
  endtask

  // Advance to the next negedge, where inputs change and outputs are sampled
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //         D    E    M   srcA srcB dstM cnd mst  wst   FDEMW     DEM
    vecs[0]  = '{4'h1,4'h1,4'h1,4'hF,4'hF,4'hF,1'b1,3'd1,3'd1,5'b00000,3'b000};
    vecs[1]  = '{4'h1,4'h5,4'h1,4'h3,4'hF,4'h3,1'b1,3'd1,3'd1,5'b11000,3'b010};
    vecs[2]  = '{4'h1,4'h5,4'h1,4'h3,4'hF,4'hF,1'b1,3'd1,3'd1,5'b00000,3'b000};
    vecs[3]  = '{4'h1,4'hB,4'h1,4'hF,4'h4,4'h4,1'b1,3'd1,3'd1,5'b11000,3'b010};
    vecs[4]  = '{4'h1,4'h5,4'h1,4'h2,4'h4,4'h3,1'b1,3'd1,3'd1,5'b00000,3'b000};
    vecs[5]  = '{4'h1,4'h7,4'h1,4'hF,4'hF,4'hF,1'b0,3'd1,3'd1,5'b00000,3'b110};
    vecs[6]  = '{4'h1,4'h7,4'h1,4'hF,4'hF,4'hF,1'b1,3'd1,3'd1,5'b00000,3'b000};
    vecs[7]  = '{4'h1,4'h1,4'h9,4'hF,4'hF,4'hF,1'b1,3'd1,3'd1,5'b10000,3'b100};
    vecs[8]  = '{4'h9,4'h1,4'h1,4'hF,4'hF,4'hF,1'b1,3'd1,3'd1,5'b10000,3'b100};
    vecs[9]  = '{4'h1,4'h9,4'h1,4'hF,4'hF,4'hF,1'b1,3'd1,3'd1,5'b10000,3'b100};
    vecs[10] = '{4'h9,4'h5,4'h1,4'h3,4'hF,4'h3,1'b1,3'd1,3'd1,5'b11000,3'b010};
    vecs[11] = '{4'h1,4'h1,4'h1,4'hF,4'hF,4'hF,1'b1,3'd3,3'd1,5'b00000,3'b001};
    vecs[12] = '{4'h1,4'h1,4'h1,4'hF,4'hF,4'hF,1'b1,3'd1,3'd4,5'b00001,3'b001};
    vecs[13] = '{4'h1,4'h1,4'h1,4'hF,4'hF,4'hF,1'b1,3'd2,3'd1,5'b00000,3'b001};
    vecs[14] = '{4'h1,4'h1,4'h1,4'hF,4'hF,4'hF,1'b1,3'd5,3'd0,5'b00000,3'b000};
    vecs[15] = '{4'h1,4'h7,4'h9,4'hF,4'hF,4'hF,1'b0,3'd1,3'd1,5'b10000,3'b110};

    nops();
    ctl(1'b1, 1'b0, 1'b0);  // start held through reset must be ignored
    rst_n = 1'b0;
    tick();
    #1;
    check("reset_state", 32'(pif.cpu_state), 32'd0);
    check("reset_halted", 32'(pif.halted), 32'd0);
    check("reset_stalls", 32'(stalls()), 32'h1F);
    check("reset_bubbles", 32'(bubbles()), 32'd0);
    tick();
    ctl(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    check("post_reset_state", 32'(pif.cpu_state), 32'd0);

    // Start pulse: IDLE now, RUN after the next edge
    tick();
    ctl(1'b1, 1'b0, 1'b0);
    #1;
    check("idle_before_start", 32'(pif.cpu_state), 32'd0);
    tick();
    ctl(1'b0, 1'b0, 1'b0);
    #1;
    check("run_after_start", 32'(pif.cpu_state), 32'd1);
    check("run_nop_stalls", 32'(stalls()), 32'd0);
    check("run_nop_bubbles", 32'(bubbles()), 32'd0);

    // Hazard table in RUN; statuses restored to AOK before each edge so RUN is kept
    for (int i = 0; i < 16; i++) begin
      tick();
      pif.D_icode = vecs[i].d_ic; pif.E_icode = vecs[i].e_ic; pif.M_icode = vecs[i].m_ic;
      pif.d_srcA = vecs[i].srca; pif.d_srcB = vecs[i].srcb; pif.E_dstM = vecs[i].dstm;
      pif.e_Cnd = vecs[i].cnd; pif.m_stat = vecs[i].mst; pif.W_stat = vecs[i].wst;
      #1;
      check($sformatf("vec%0d_stalls", i), 32'(stalls()), 32'(vecs[i].stl));
      check($sformatf("vec%0d_bubbles", i), 32'(bubbles()), 32'(vecs[i].bub));
      #1;
      nops();
    end
    tick();
    check("run_kept_after_table", 32'(pif.cpu_state), 32'd1);

    // Start in RUN ignored; pause returns to IDLE with frozen outputs
    ctl(1'b1, 1'b0, 1'b0);
    tick();
    #1;
    check("start_ignored_in_run", 32'(pif.cpu_state), 32'd1);
    ctl(1'b0, 1'b0, 1'b1);
    tick();
    ctl(1'b0, 1'b0, 1'b0);
    #1;
    check("pause_to_idle", 32'(pif.cpu_state), 32'd0);
    pif.E_icode = 4'h7; pif.e_Cnd = 1'b0;
    #1;
    check("idle_frozen_stalls", 32'(stalls()), 32'h1F);
    check("idle_frozen_bubbles", 32'(bubbles()), 32'd0);
    nops();

    // Step: one cycle in STEP with live hazard outputs, then IDLE
    ctl(1'b0, 1'b1, 1'b0);
    tick();
    ctl(1'b0, 1'b1, 1'b1);  // pulses in STEP are ignored
    pif.E_icode = 4'h7; pif.e_Cnd = 1'b0;
    #1;
    check("step_state", 32'(pif.cpu_state), 32'd2);
    check("step_bubbles", 32'(bubbles()), 32'b110);
    tick();
    ctl(1'b0, 1'b0, 1'b0);
    nops();
    #1;
    check("step_back_idle", 32'(pif.cpu_state), 32'd0);

    // Exception while IDLE does not halt
    pif.W_stat = 3'd3;
    tick();
    pif.W_stat = 3'd1;
    #1;
    check("idle_ignores_exc", 32'(pif.cpu_state), 32'd0);

    // Step with exception goes to HALT
    ctl(1'b0, 1'b1, 1'b0);
    tick();
    ctl(1'b0, 1'b0, 1'b0);
    pif.W_stat = 3'd2;
    tick();
    pif.W_stat = 3'd1;
    #1;
    check("step_exc_halt", 32'(pif.cpu_state), 32'd3);
    do_reset();
    #1;
    check("reset_from_halt_a", 32'(pif.cpu_state), 32'd0);

    // Start and step together -> RUN
    ctl(1'b1, 1'b1, 1'b0);
    tick();
    ctl(1'b0, 1'b0, 1'b0);
    #1;
    check("start_over_step", 32'(pif.cpu_state), 32'd1);

    // Exception with pause -> HALT
    pif.W_stat = 3'd3;
    ctl(1'b0, 1'b0, 1'b1);
    #1;
    check("exc_m_bubble", 32'(pif.M_bubble), 32'd1);
    check("exc_w_stall", 32'(pif.W_stall), 32'd1);
    tick();
    ctl(1'b0, 1'b0, 1'b0);
    pif.W_stat = 3'd1;
    #1;
    check("halt_state", 32'(pif.cpu_state), 32'd3);
    check("halt_halted", 32'(pif.halted), 32'd1);
    check("halt_stalls", 32'(stalls()), 32'h1F);
    ctl(1'b1, 1'b1, 1'b1);
    tick();
    tick();
    ctl(1'b0, 1'b0, 1'b0);
    #1;
    check("halt_sticky", 32'(pif.cpu_state), 32'd3);
    do_reset();
    #1;
    check("reset_from_halt_b", 32'(pif.cpu_state), 32'd0);
    check("reset_from_halt_halted", 32'(pif.halted), 32'd0);

`ifdef PIPE_PERF_CNT_EN
    do_reset();
    ctl(1'b1, 1'b0, 1'b0);
    tick();
    ctl(1'b0, 1'b0, 1'b0);
    // Ten RUN cycles: load-use on cycles 3 and 4, mispredict on cycle 7, pause on cycle 10
    for (int k = 1; k <= 10; k++) begin
      nops();
      if (k == 3 || k == 4) begin
        pif.E_icode = 4'h5; pif.E_dstM = 4'h3; pif.d_srcA = 4'h3;
      end
      if (k == 7) begin
        pif.E_icode = 4'h7; pif.e_Cnd = 1'b0;
      end
      if (k == 10) ctl(1'b0, 1'b0, 1'b1);
      tick();
    end
    ctl(1'b0, 1'b0, 1'b0);
    nops();
    #1;
    check("perf_idle", 32'(pif.cpu_state), 32'd0);
    check("perf_cyc", pif.cyc_cnt, 32'd10);
    check("perf_stall", pif.stall_cnt, 32'd2);
    check("perf_mispred", pif.mispred_cnt, 32'd1);
    dut.cyc_cnt_q = 32'hFFFF_FFFF;
    ctl(1'b1, 1'b0, 1'b0);
    tick();
    ctl(1'b0, 1'b0, 1'b0);
    tick();
    #1;
    check("perf_wrap", pif.cyc_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports D_icode, E_icode, M_icode  input  4 each  icode held in the D, E and M pipeline registers.
REQ-004 SHALL have ports d_srcA, d_srcB  input  4 each  decode source register IDs; E_dstM  input  4  memory destination register in E (0xF = none).
REQ-005 SHALL have port e_Cnd  input  1  branch condition computed in execute.
REQ-006 SHALL have ports m_stat, W_stat  input  3 each  status codes: 1 AOK, 2 HLT, 3 ADR, 4 INS.
REQ-007 SHALL have ports start, step, pause  input  1 each  single-cycle run-control pulses.
REQ-008 SHALL have ports F_stall, D_stall, E_stall, M_stall, W_stall  output  1 each  hold the named pipeline register.
REQ-009 SHALL have ports D_bubble, E_bubble, M_bubble  output  1 each  load a NOP into the named register.
REQ-010 SHALL have port cpu_state  output  2  00 IDLE, 01 RUN, 10 STEP, 11 HALT; halted  output  1  equals (cpu_state==HALT).

Function
REQ-011 SHALL define load_use = (E_icode==5 or E_icode==0xB) and E_dstM!=0xF and (E_dstM==d_srcA or E_dstM==d_srcB).
REQ-012 SHALL define ret_hz = any of D_icode, E_icode, M_icode equal to 9; mispred = (E_icode==7 and !e_Cnd).
REQ-013 SHALL define exc_m = m_stat in {2,3,4}; exc_w = W_stat in {2,3,4}.
REQ-014 SHALL, in RUN or STEP: F_stall = load_use|ret_hz; D_stall = load_use; D_bubble = mispred | (ret_hz & !load_use); E_bubble = mispred | load_use; M_bubble = exc_m | exc_w; W_stall = exc_w; E_stall = M_stall = 0.
REQ-015 SHALL, in IDLE or HALT, assert all five stall outputs and deassert all bubble outputs (pipeline frozen).
REQ-016 SHALL drive all stall/bubble outputs combinationally from the current state and inputs (zero latency).
REQ-017 SHALL apply state transitions: IDLE+start -> RUN; IDLE+step (no start) -> STEP; STEP -> IDLE after exactly one cycle; RUN+pause -> IDLE; any state except IDLE with exc_w -> HALT.
REQ-018 SHALL treat HALT as terminal; start, step and pause are ignored until reset.
REQ-019 SHALL give exc_w priority over pause, and start priority over step, when they coincide.
REQ-020 SHALL ignore start in RUN, and start/step/pause in STEP.
REQ-021 SHALL give exc_w in STEP the transition to HALT instead of IDLE.

Reset
REQ-022 SHALL, while rst_n==0 at a rising clk edge, set cpu_state=IDLE (halted=0) and clear all counters.
REQ-023 SHALL override any in-progress state (including HALT) with reset and ignore run-control pulses in the reset cycle.
REQ-024 SHALL hold outputs at the IDLE values from REQ-015 during and immediately after reset.

Configuration
REQ-025 SHALL, with macro PIPE_PERF_CNT_EN defined, add outputs cyc_cnt, stall_cnt and mispred_cnt (32 bits each, wrap at 2^32).
REQ-026 SHALL, with PIPE_PERF_CNT_EN defined, count per cycle: cyc_cnt in RUN/STEP; stall_cnt in RUN/STEP when F_stall; mispred_cnt in RUN/STEP when mispred.
REQ-027 SHALL, without PIPE_PERF_CNT_EN, omit those ports and counters entirely, with no other behaviour change.

Verification
REQ-028 SHALL cover: reset, then start pulse -> cpu_state 00 then 01 next cycle; all stalls 0 with D/E/M_icode=1, E_icode=1.
REQ-029 SHALL cover: RUN with E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; the same stimulus with E_dstM=0xF -> all 0.
REQ-030 SHALL cover: RUN with E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1; the same with M_icode=9 -> F_stall=1, D_bubble=1.
REQ-031 SHALL cover: IDLE+step -> STEP (10) for one cycle, then IDLE; start and step in the same cycle -> RUN.
REQ-032 SHALL cover: RUN, W_stat=3 together with pause -> M_bubble=1, W_stall=1, next cycle HALT with halted=1; start then ignored; rst_n=0 -> IDLE.
REQ-033 SHALL cover, with PIPE_PERF_CNT_EN: 10 RUN cycles containing 2 load-use cycles and 1 mispredict -> cyc_cnt=10, stall_cnt=2, mispred_cnt=1; cyc_cnt preset near 0xFFFFFFFF wraps to 0.
